// File: rtl/partition_sweep_eval_pkg.sv
// Shared types and width helpers for the partition sweep-and-score stage.
package partition_eval_pkg;

   localparam int DEF_IN_W  = 7;
   localparam int DEF_OUT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Hamming sum must hold OUT_W mismatching bits on every one of 2^IN_W vectors.
   function automatic int hd_width(input int in_w, input int out_w);
      return in_w + $clog2(out_w + 1);
   endfunction

   function automatic int abs_width(input int in_w, input int out_w);
      return in_w + out_w;
   endfunction

endpackage

// File: rtl/partition_sweep_eval_if.sv
// Stimulus/response and metric bundle between the sweep stage and its environment.
interface partition_sweep_eval_if
   import partition_eval_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int HD_W  = hd_width(IN_W, OUT_W),
   parameter int AS_W  = abs_width(IN_W, OUT_W)
) ();

   logic              start;
   logic              abort;
   logic [IN_W-1:0]   pi;
   logic [OUT_W-1:0]  po_exact;
   logic [OUT_W-1:0]  po_approx;
   logic              busy;
   logic              done;
   logic [IN_W:0]     err_count;
   logic [HD_W-1:0]   hd_sum;
   logic [AS_W-1:0]   abs_sum;
   logic [OUT_W-1:0]  max_abs;

   modport slave (
      input  start, abort, po_exact, po_approx,
      output pi, busy, done, err_count, hd_sum, abs_sum, max_abs
   );

   modport master (
      output start, abort, po_exact, po_approx,
      input  pi, busy, done, err_count, hd_sum, abs_sum, max_abs
   );

endinterface

// File: rtl/partition_sweep_eval_err_metric_unit.sv
// Combinational mismatch flag, popcount(xor) and |exact - approx| for one output pair.
module err_metric_unit
   import partition_eval_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W,
   parameter int PC_W  = $clog2(OUT_W + 1)
) (
   input  logic [OUT_W-1:0] i_exact,
   input  logic [OUT_W-1:0] i_approx,
   output logic             o_mismatch,
   output logic [PC_W-1:0]  o_popcnt,
   output logic [OUT_W-1:0] o_abs
);

   logic [OUT_W-1:0]        w_xor;
   logic signed [OUT_W:0]   w_diff;

   assign w_xor      = i_exact ^ i_approx;
   assign o_mismatch = |w_xor;

   // One extra bit keeps the difference exact; the magnitude always fits back in OUT_W.
   assign w_diff = $signed({1'b0, i_exact}) - $signed({1'b0, i_approx});
   assign o_abs  = w_diff[OUT_W] ? OUT_W'(-w_diff) : OUT_W'(w_diff);

   always_comb begin
      o_popcnt = '0;
      for (int i = 0; i < OUT_W; i++) begin
         o_popcnt = o_popcnt + PC_W'(w_xor[i]);
      end
   end

endmodule

// File: rtl/partition_sweep_eval.sv
// Exhaustive input sweep of a partition with a one-cycle capture stage and error accumulators.
module partition_sweep_eval
   import partition_eval_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int HD_W  = hd_width(IN_W, OUT_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   partition_sweep_eval_if.slave bus
);

   localparam int PC_W = $clog2(OUT_W + 1);
   localparam int AS_W = abs_width(IN_W, OUT_W);
   localparam logic [IN_W-1:0] PI_LAST = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_clr;
   logic              w_accum;

   logic [IN_W-1:0]   r_pi;
   logic [OUT_W-1:0]  r_exact_p0;
   logic [OUT_W-1:0]  r_approx_p0;
   logic              r_vld_p0;

   logic              w_mis;
   logic [PC_W-1:0]   w_pc;
   logic [OUT_W-1:0]  w_abs;

   logic [IN_W:0]     r_err_count;
   logic [HD_W-1:0]   r_hd_sum;
   logic [AS_W-1:0]   r_abs_sum;
   logic [OUT_W-1:0]  r_max_abs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // abort dominates start; start is only honoured from IDLE or DONE
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_accum     = r_vld_p0 && !bus.abort;
      if (bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  w_state_nxt = SWEEP;
                  w_clr       = 1'b1;
               end
            end
            SWEEP:   if (r_pi == PI_LAST) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Stage p0: drive pi and capture both partition responses to it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pi        <= '0;
         r_exact_p0  <= '0;
         r_approx_p0 <= '0;
         r_vld_p0    <= 1'b0;
      end else begin
         if (bus.abort || w_clr)   r_pi <= '0;
         else if (r_state == SWEEP) r_pi <= r_pi + 1'b1;
         r_vld_p0 <= (r_state == SWEEP) && !bus.abort;
         if (r_state == SWEEP) begin
            r_exact_p0  <= bus.po_exact;
            r_approx_p0 <= bus.po_approx;
         end
      end
   end

   err_metric_unit #(
      .OUT_W (OUT_W),
      .PC_W  (PC_W)
   ) u_metric (
      .i_exact    (r_exact_p0),
      .i_approx   (r_approx_p0),
      .o_mismatch (w_mis),
      .o_popcnt   (w_pc),
      .o_abs      (w_abs)
   );

   // Stage p1: fold the captured pair into the accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
         r_hd_sum    <= '0;
         r_abs_sum   <= '0;
         r_max_abs   <= '0;
      end else if (w_clr) begin
         r_err_count <= '0;
         r_hd_sum    <= '0;
         r_abs_sum   <= '0;
         r_max_abs   <= '0;
      end else if (w_accum) begin
         r_err_count <= r_err_count + (IN_W+1)'(w_mis);
         r_hd_sum    <= r_hd_sum + HD_W'(w_pc);
         r_abs_sum   <= r_abs_sum + AS_W'(w_abs);
         if (w_abs > r_max_abs) r_max_abs <= w_abs;
      end
   end

   assign bus.pi        = r_pi;
   assign bus.busy      = (r_state == SWEEP) || (r_state == DRAIN);
   assign bus.done      = (r_state == DONE);
   assign bus.err_count = r_err_count;
   assign bus.hd_sum    = r_hd_sum;
   assign bus.abs_sum   = r_abs_sum;
   assign bus.max_abs   = r_max_abs;

endmodule
